// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder: trellis sequencer states,
// ACS path-select encodings and the default frame geometry.
package viterbi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FIRST,
    S_RUN,
    S_TAIL,
    S_TB,
    S_DONE
  } state_e;

  localparam logic [1:0] SEL_BR1 = 2'b00;
  localparam logic [1:0] SEL_CMP = 2'b01;
  localparam logic [1:0] SEL_BR2 = 2'b10;

  localparam int BLOCK_LEN_DEF = 8;
  localparam int TAIL_LEN_DEF  = 2;

endpackage

// File: rtl/step_counter.sv
// Trellis step counter with synchronous clear, increment enable and
// terminal compares for the last information step and the last tail step.
module step_counter #(
  parameter int CNT_W     = 4,
  parameter int BLOCK_LEN = 8,
  parameter int TAIL_LEN  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_info_o,
  output logic             last_tail_o
);

  localparam logic [CNT_W-1:0] LAST_INFO = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(BLOCK_LEN + TAIL_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign last_info_o = (cnt_q == LAST_INFO);
  assign last_tail_o = (cnt_q == LAST_TAIL);

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Trellis sequencer for the ACS array: walks a frame through clear, first
// step, steady state and tail flush, then launches traceback and waits.
module viterbi_acs_ctrl
  import viterbi_pkg::*;
#(
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int TAIL_LEN  = TAIL_LEN_DEF,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             acs_en,
  output logic [1:0]       acs_sel,
  output logic             acs_clear,
  output logic [CNT_W-1:0] step,
  output logic             tb_start,
  input  logic             tb_done,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;
  logic   tb_first_q, tb_first_d;
  logic   hs, cnt_clr, last_info, last_tail;

  assign hs     = sym_valid & sym_ready;
  assign acs_en = hs;

  // Clearing on entry to CLEAR as well makes step read 0 throughout CLEAR.
  assign cnt_clr    = ((state_q == S_IDLE) & start) | (state_q == S_CLEAR);
  assign tb_first_d = (state_q == S_TAIL) & hs & last_tail;

  step_counter #(
    .CNT_W    (CNT_W),
    .BLOCK_LEN(BLOCK_LEN),
    .TAIL_LEN (TAIL_LEN)
  ) u_step_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (cnt_clr),
    .inc_i      (hs),
    .cnt_o      (step),
    .last_info_o(last_info),
    .last_tail_o(last_tail)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tb_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tb_first_q <= tb_first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FIRST;
      S_FIRST: if (hs) state_d = S_RUN;
      S_RUN:   if (hs && last_info) state_d = S_TAIL;
      S_TAIL:  if (hs && last_tail) state_d = S_TB;
      S_TB:    if (tb_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sym_ready = 1'b0;
    acs_sel   = SEL_BR1;
    acs_clear = 1'b0;
    tb_start  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    case (state_q)
      S_CLEAR: acs_clear = 1'b1;
      S_FIRST: sym_ready = 1'b1;
      S_RUN: begin
        sym_ready = 1'b1;
        acs_sel   = SEL_CMP;
      end
      S_TAIL:  sym_ready = 1'b1;
      S_TB:    tb_start  = tb_first_q;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Scoreboard bench for viterbi_acs_ctrl: per-frame expected ACS selects and
// step values are queued at stimulus time and popped on each handshake.
module tb_viterbi_acs_ctrl;
  localparam int BL = 8;
  localparam int TL = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n, start, sym_valid, tb_done;
  logic          sym_ready, acs_en, acs_clear, tb_start, busy, done;
  logic [1:0]    acs_sel;
  logic [CW-1:0] step;

  viterbi_acs_ctrl #(.BLOCK_LEN(BL), .TAIL_LEN(TL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .acs_en(acs_en), .acs_sel(acs_sel),
    .acs_clear(acs_clear), .step(step), .tb_start(tb_start),
    .tb_done(tb_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         stp;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0, n_chk = 0, cyc = 0;
  int   n_done = 0, f_hs = 0, f_clr = 0, f_tbs = 0;
  int   f_clr_c = 0, f_tbs_c = 0, f_done_c = 0, last_done_c = 0, rise_c = 0;
  bit   b2b = 0, have_done = 0, in_tb = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < BL + TL; i++) begin
      e.stp = i;
      e.sel = (i == 0) ? 2'b00 : (i < BL) ? 2'b01 : 2'b00;
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (acs_clear) begin
      f_clr++;
      f_clr_c = cyc;
      chk("clr_step", step, 0);
      chk("clr_en", acs_en, 0);
      if (b2b && have_done) chk("b2b_gap", cyc - last_done_c, 2);
    end
    if (!sym_ready) chk("en_noready", acs_en, 0);
    else if (sym_valid) chk("en_hs", acs_en, 1);
    if (acs_en) begin
      f_hs++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sel", acs_sel, e.sel);
        chk("step", step, e.stp);
      end
    end else if (sym_ready && sb.size() > 0) begin
      chk("stall_sel", acs_sel, sb[0].sel);
      chk("stall_step", step, sb[0].stp);
    end
    if (tb_start) begin
      f_tbs++;
      f_tbs_c = cyc;
      in_tb = 1;
      chk("tbs_rdy", sym_ready, 0);
    end
    if (in_tb) chk("tb_busy", busy, 1);
    if (done) begin
      n_done++;
      f_done_c = cyc;
      last_done_c = cyc;
      have_done = 1;
      in_tb = 0;
      chk("done_busy", busy, 1);
    end
    if (!busy)
      chk("idle_out", {sym_ready, acs_en, acs_sel, acs_clear, tb_start, done}, 0);
  end

  task automatic run_frame(input bit stalls, input int tb_wait, input bit poke);
    int  stall_left = 0, tbw = 0, guard = 0, d0, t_start;
    bit  tb_seen = 0, prev_tbd;
    bit [15:0] stalled = '0;
    d0 = n_done; f_hs = 0; f_clr = 0; f_tbs = 0;
    push_frame();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    t_start = cyc;
    prev_tbd = tb_done;
    while (n_done == d0 && guard < 300) begin
      if (stall_left > 0) begin
        sym_valid = 0; stall_left--;
      end else if (stalls && sym_ready && (step == 0 || step == 5 || step == 8) && !stalled[step]) begin
        stalled[step] = 1; sym_valid = 0; stall_left = 2;
      end else sym_valid = 1;
      if (tb_start) begin tb_seen = 1; tbw = tb_wait; end
      tb_done = tb_seen ? (tbw == 0) : (tb_wait == 0);
      if (tb_done && !prev_tbd) rise_c = cyc;
      prev_tbd = tb_done;
      if (tb_seen && tbw > 0) tbw--;
      start = poke && ((sym_ready && step == 4) || (tb_seen && tbw == 10));
      @(posedge clk); #1;
      guard++;
    end
    sym_valid = 0; start = 0; tb_done = 0;
    if (guard >= 300) chk("frame_timeout", 0, 1);
    chk("hs_cnt", f_hs, BL + TL);
    chk("tbs_cnt", f_tbs, 1);
    chk("clr_cnt", f_clr, 1);
    chk("clr_cyc", f_clr_c, t_start);
    chk("sb_left", sb.size(), 0);
    if (!stalls && tb_wait == 0) begin
      chk("tbs_lat", f_tbs_c - f_clr_c, BL + TL + 1);
      chk("done_lat", f_done_c - f_clr_c, BL + TL + 2);
    end
    if (tb_wait > 0) begin
      chk("tbs_to_tbd", rise_c - f_tbs_c, tb_wait);
      chk("done_after_tbd", f_done_c, rise_c + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("one_done", n_done, d0 + 1);
    chk("end_idle", busy, 0);
    chk("end_step", step, BL + TL);
  endtask

  initial begin
    int guard, d0;
    reset_n = 0; start = 0; sym_valid = 0; tb_done = 0;
    #3;
    chk("rst_out", {sym_ready, acs_en, acs_sel, acs_clear, tb_start, busy, done}, 0);
    chk("rst_step", step, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // Stray inputs in IDLE must not start anything.
    sym_valid = 1; tb_done = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_step", step, 0);
    sym_valid = 0; tb_done = 0;
    @(posedge clk); #1;

    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(0, 20, 1);

    // Reset in the middle of RUN at step 3.
    d0 = n_done; f_tbs = 0;
    push_frame();
    start = 1; sym_valid = 1; tb_done = 1;
    @(posedge clk); #1;
    start = 0;
    guard = 0;
    while (!(sym_ready && step == 3) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("rst_wait_timeout", 0, 1);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_out", {sym_ready, acs_en, acs_sel, acs_clear, tb_start, busy, done}, 0);
    chk("mid_rst_step", step, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", n_done, d0);
    chk("rst_no_tbs", f_tbs, 0);
    chk("rst_idle", busy, 0);
    sym_valid = 0; tb_done = 0;

    // Back-to-back frames with start held high.
    b2b = 1; have_done = 0; f_clr = 0; d0 = n_done;
    repeat (3) push_frame();
    start = 1; sym_valid = 1; tb_done = 1;
    guard = 0;
    while (n_done < d0 + 3 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    start = 0;
    if (guard >= 200) chk("b2b_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_frames", f_clr, 3);
    chk("b2b_sb", sb.size(), 0);
    chk("b2b_idle", busy, 0);
    b2b = 0; sym_valid = 0; tb_done = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/viterbi_acs_ctrl.md
# viterbi_acs_ctrl

Trellis sequencer for the Viterbi decoder's ACS array. It accepts one received symbol per trellis step through a valid/ready handshake and generates the shared ACS controls: `acs_en`, `acs_sel` and `acs_clear`. It walks a frame through four phases: metric clear, first step, steady state and tail flush. It then hands the frame to the traceback unit and waits for completion. It sits between the branch-metric front end and the ACS bank, one instance per decoder.

## Interface
Parameters:
- `BLOCK_LEN`, default 8: information bits per frame; legal range is 2 or more.
- `TAIL_LEN`, default 2: tail (flush) steps per frame, equal to K-1; legal range is 1 or more.
- `CNT_W`, default 4: step counter width; must satisfy 2^CNT_W > BLOCK_LEN+TAIL_LEN.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `sym_valid`  in  1  branch metrics for the current step are valid.
- `sym_ready`  out  1  the controller can consume a symbol this cycle.
- `acs_en`  out  1  ACS path-metric register update enable.
- `acs_sel`  out  2  ACS path select: 00 = force branch 1, 01 = compare/select, 10 = force branch 2.
- `acs_clear`  out  1  one-cycle clear of the ACS path-metric registers.
- `step`  out  CNT_W  number of trellis steps completed in the current frame.
- `tb_start`  out  1  one-cycle traceback launch.
- `tb_done`  in  1  traceback finished.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, CLEAR, FIRST, RUN, TAIL, TB, DONE. The state is one-hot or binary; the encoding is not visible at the ports.
- IDLE:
  - All outputs are 0 and `acs_sel` is 00.
  - `start`=1 moves to CLEAR.
- CLEAR:
  - `acs_clear`=1 and `step` is cleared to 0.
  - Always moves to FIRST after one cycle.
- FIRST:
  - `sym_ready`=1, `acs_sel`=00.
  - Only the state-0 branch is valid, so comparison is suppressed.
  - On a handshake (`sym_valid`&`sym_ready`), `step` increments and the state moves to RUN.
- RUN:
  - `sym_ready`=1, `acs_sel`=01.
  - Each handshake increments `step`.
  - A handshake with `step`==BLOCK_LEN-1 moves to TAIL.
- TAIL:
  - `sym_ready`=1, `acs_sel`=00, so only zero-input branches survive.
  - Each handshake increments `step`.
  - A handshake with `step`==BLOCK_LEN+TAIL_LEN-1 moves to TB.
- TB:
  - `tb_start`=1 in the first TB cycle only; `sym_ready`=0.
  - `tb_done`=1 in any TB cycle, including the first, moves to DONE.
- DONE:
  - `done`=1 for one cycle, then the state returns to IDLE.
- `acs_en` is combinational and equals `sym_valid & sym_ready`, so the ACS registers load on the same edge as the handshake.
- `acs_sel` is decoded from the state only.
- `step` reaches BLOCK_LEN+TAIL_LEN on entry to TB and holds until the next CLEAR.
- `start` outside IDLE is ignored; it is neither queued nor an abort.
- `sym_valid` outside FIRST/RUN/TAIL has no effect.
- `tb_done` outside TB is ignored.
- `busy` is 1 from CLEAR through DONE inclusive.

## Timing
- Reset: the state goes to IDLE immediately on `reset_n` falling, without waiting for `clk`.
- Values while in reset: `step`=0, `sym_ready`=0, `acs_en`=0, `acs_sel`=00, `acs_clear`=0, `tb_start`=0, `busy`=0, `done`=0.
- Reset in the middle of a frame abandons the frame: there is no `done` and no `tb_start`.
- Latency with continuous `sym_valid` and `tb_done` already high:
  - `start` high at edge N puts CLEAR in cycle N+1.
  - The first handshake is in cycle N+2.
  - The last symbol handshake is in cycle N+1+BLOCK_LEN+TAIL_LEN.
  - `tb_start` is high in the next cycle.
  - `done` is high in the cycle after that.
- Stalls: `sym_valid` low simply holds the state. There is no timeout.
- `acs_clear` and `acs_en` are never high in the same cycle.
- `tb_start` and `sym_ready` are never high in the same cycle.
- Back-to-back frames: `start` held high during DONE has no effect. It is sampled again in IDLE, one cycle later, which gives a 2-cycle minimum gap between frames.

## Structure
- Shared package `viterbi_pkg` holds:
  - the state enumeration;
  - the `acs_sel` encodings `SEL_BR1`=2'b00, `SEL_CMP`=2'b01, `SEL_BR2`=2'b10;
  - the default BLOCK_LEN and TAIL_LEN shared with the traceback unit.
- Natural sub-module: `step_counter`, a CNT_W-bit counter with synchronous clear and increment-enable, plus terminal-compare outputs `last_info` and `last_tail`.
- The FSM and output decode stay in the top module.

## Test plan
- Reset/idle: assert `reset_n`=0 mid-RUN at step 3. All outputs read 0 immediately, and after release the block stays in IDLE with no `done`.
- Nominal frame (BLOCK_LEN=8, TAIL_LEN=2):
  - Drive `start`, then continuous `sym_valid`, with `tb_done` tied to 1.
  - Expect `acs_clear` in cycle 1.
  - Expect `acs_sel`=00 at step 0, 01 for steps 1-7 and 00 for steps 8-9.
  - Expect `tb_start` in cycle 12 and `done` in cycle 13.
- Stalls: drop `sym_valid` for 3 cycles at steps 0, 5 and 8.
  - `acs_en`=0 and `step` holds during each stall.
  - The `acs_sel` sequence is unchanged.
  - Total handshakes equal 10.
- Traceback wait: hold `tb_done`=0 for 20 cycles.
  - `tb_start` pulses exactly once.
  - `busy` stays 1.
  - `done` appears one cycle after `tb_done` rises.
- Ignored inputs:
  - Pulse `start` during RUN and TB.
  - Assert `sym_valid` and `tb_done` in IDLE.
  - There are no state changes, no `acs_en`, and exactly one `done` per frame.
- Back-to-back: hold `start`=1 continuously. Frames repeat with `done`-to-`acs_clear` spacing of exactly 2 cycles, and `step` restarts at 0.
